mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_pkg.sv | 67 ++++++
 rtl/mc_control_unit_if.sv | 44 ++++
 rtl/instr_decoder.sv | 48 ++++
 rtl/mc_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: FSM states, opcode/func constants,
// operand/PC select encodings and the instruction class bundle.
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  // PC source select
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  // One-hot instruction class; nop catches every undefined encoding.
  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic lwd;
    logic swd;
    logic br;
    logic jmp;
    logic jal;
    logic jpr;
    logic jrl;
    logic wwd;
    logic hlt;
    logic nop;
  } cls_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: controller <-> datapath/memory bundle.
// master = controller (drives strobes/selects), slave = datapath.
interface mc_control_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
);

  logic [WORD_SIZE-1:0] instr;
  logic                 mem_ready;
  logic                 br_taken;
  logic                 mem_read;
  logic                 mem_write;
  logic                 i_or_d;
  logic                 ir_write;
  logic                 pc_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           pc_source;
  logic                 wwd;
  logic                 halt;
  logic                 timeout_err;
  logic [CNT_WIDTH-1:0] num_inst;

  modport master (
    input  instr, mem_ready, br_taken,
    output mem_read, mem_write, i_or_d,
           ir_write, pc_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b,
           pc_source, wwd, halt,
           timeout_err, num_inst
  );

  modport slave (
    output instr, mem_ready, br_taken,
    input  mem_read, mem_write, i_or_d,
           ir_write, pc_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b,
           pc_source, wwd, halt,
           timeout_err, num_inst
  );

endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: maps instr to one-hot class flags (cls_t).
// Ports: instr in (WORD_SIZE), cls out; undefined -> cls.nop.
module instr_decoder
  import mc_control_unit_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] instr,
  output cls_t                 cls
);

  logic [3:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op = instr[WORD_SIZE-1 -: 4];
  assign fn = instr[5:0];
  // register fields are decoded by the datapath
  assign unused_bits = ^instr;

  always_comb begin
    cls = '0;
    unique case (op)
      OP_BNE, OP_BEQ,
      OP_BGZ, OP_BLZ: cls.br    = 1'b1;
      OP_ADI, OP_ORI,
      OP_LHI:         cls.alu_i = 1'b1;
      OP_LWD:         cls.lwd   = 1'b1;
      OP_SWD:         cls.swd   = 1'b1;
      OP_JMP:         cls.jmp   = 1'b1;
      OP_JAL:         cls.jal   = 1'b1;
      OP_R: begin
        unique case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL,
          FN_SHR:  cls.alu_r = 1'b1;
          FN_JPR:  cls.jpr   = 1'b1;
          FN_JRL:  cls.jrl   = 1'b1;
          FN_WWD:  cls.wwd   = 1'b1;
          FN_HLT:  cls.hlt   = 1'b1;
          default: cls.nop   = 1'b1;
        endcase
      end
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle IF/ID/EX/MEM/WB/HALT controller.
// Ports: clk, reset (sync, active-high), bus (master modport).
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  mc_control_unit_if.master bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t               state;
  state_t               next_state;
  cls_t                 cls;
  logic [TW-1:0]        wait_cnt;
  logic [CNT_WIDTH-1:0] num_inst;
  logic                 terr_q;
  logic                 retire;
  logic                 tmo;
  logic                 in_access;

  instr_decoder #(
    .WORD_SIZE(WORD_SIZE)
  ) u_dec (
    .instr(bus.instr),
    .cls  (cls)
  );

  // only IF and MEM ever hold a memory strobe
  assign in_access = (state == S_IF) ||
                     (state == S_MEM);

  // the MEM_TIMEOUT-th consecutive not-ready cycle
  assign tmo = in_access && !bus.mem_ready &&
               (wait_cnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    unique case (state)
      S_IF: begin
        if (bus.mem_ready) next_state = S_ID;
        else if (tmo)      next_state = S_HALT;
      end
      S_ID: begin
        unique case (1'b1)
          cls.jmp, cls.jal,
          cls.wwd, cls.nop: begin
            next_state = S_IF;
            retire     = 1'b1;
          end
          cls.hlt: begin
            next_state = S_HALT;
            retire     = 1'b1;
          end
          default: next_state = S_EX;
        endcase
      end
      S_EX: begin
        unique case (1'b1)
          cls.alu_r, cls.alu_i: next_state = S_WB;
          cls.lwd, cls.swd:     next_state = S_MEM;
          default: begin
            next_state = S_IF;
            retire     = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (cls.lwd) begin
            next_state = S_WB;
          end else begin
            next_state = S_IF;
            retire     = 1'b1;
          end
        end else if (tmo) begin
          next_state = S_HALT;
        end
      end
      S_WB: begin
        next_state = S_IF;
        retire     = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      num_inst <= '0;
      wait_cnt <= '0;
      terr_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (retire)
        num_inst <= num_inst + CNT_WIDTH'(1);
      if (tmo)
        terr_q <= 1'b1;
      if (in_access && !bus.mem_ready && !tmo)
        wait_cnt <= wait_cnt + TW'(1);
      else
        wait_cnt <= '0;
    end
  end

  assign bus.num_inst    = num_inst;
  assign bus.timeout_err = terr_q && !reset;

  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.pc_source  = PC_INC;
    bus.wwd        = 1'b0;
    bus.halt       = 1'b0;
    if (!reset) begin
      unique case (state)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_ONE;
          if (bus.mem_ready) begin
            bus.ir_write  = 1'b1;
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_INC;
          end
        end
        S_ID: begin
          // ALU forms the branch target PC+imm
          bus.alu_src_b = SRCB_IMM;
          if (cls.jmp || cls.jal) begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_JUMP;
          end
          bus.reg_write = cls.jal;
          bus.wwd       = cls.wwd;
        end
        S_EX: begin
          bus.alu_src_a = 1'b1;
          if (cls.alu_i || cls.lwd || cls.swd)
            bus.alu_src_b = SRCB_IMM;
          if (cls.br && bus.br_taken) begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_BRANCH;
          end
          if (cls.jpr || cls.jrl) begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_REG;
          end
          bus.reg_write = cls.jrl;
        end
        S_MEM: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = cls.lwd;
          bus.mem_write = cls.swd;
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = cls.lwd;
        end
        S_HALT:  bus.halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: random + directed bench with an
// instruction-level reference model for mc_control_unit.
module tb_mc_control_unit;

  localparam int CW = 4;
  localparam int K_NOP = 0;
  localparam int K_ALU = 1;
  localparam int K_LWD = 2;
  localparam int K_SWD = 3;
  localparam int K_BR  = 4;
  localparam int K_JMP = 5;
  localparam int K_JAL = 6;
  localparam int K_JPR = 7;
  localparam int K_JRL = 8;
  localparam int K_WWD = 9;
  localparam int K_HLT = 10;

  typedef struct packed {
    logic       mr;
    logic       mw;
    logic       iod;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       m2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic       wwd;
    logic       halt;
    logic       terr;
  } smp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  int   model_cnt = 0;
  int   lat_if = 0;
  int   lat_mem = 0;
  int   pend = 0;
  smp_t tr [64];
  smp_t s;
  int   cnt;

  always #5 clk = ~clk;

  mc_control_unit_if #(
    .WORD_SIZE(16),
    .CNT_WIDTH(CW)
  ) bus ();

  mc_control_unit #(
    .WORD_SIZE  (16),
    .CNT_WIDTH  (CW),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic smp_t grab();
    smp_t r;
    r.mr   = bus.mem_read;
    r.mw   = bus.mem_write;
    r.iod  = bus.i_or_d;
    r.irw  = bus.ir_write;
    r.pcw  = bus.pc_write;
    r.rw   = bus.reg_write;
    r.m2r  = bus.mem_to_reg;
    r.asa  = bus.alu_src_a;
    r.asb  = bus.alu_src_b;
    r.pcs  = bus.pc_source;
    r.wwd  = bus.wwd;
    r.halt = bus.halt;
    r.terr = bus.timeout_err;
    return r;
  endfunction

  function automatic int kind(input logic [15:0] ins);
    int op;
    int fn;
    op = int'(ins[15:12]);
    fn = int'(ins[5:0]);
    if (op <= 3) return K_BR;
    if (op >= 4 && op <= 6) return K_ALU;
    if (op == 7) return K_LWD;
    if (op == 8) return K_SWD;
    if (op == 9) return K_JMP;
    if (op == 10) return K_JAL;
    if (op == 15) begin
      if (fn <= 7) return K_ALU;
      if (fn == 25) return K_JPR;
      if (fn == 26) return K_JRL;
      if (fn == 28) return K_WWD;
      if (fn == 29) return K_HLT;
    end
    return K_NOP;
  endfunction

  function automatic logic [15:0] rnd_instr();
    logic [3:0] op;
    logic [5:0] fn;
    logic [5:0] mid;
    int         p;
    op  = 4'($urandom_range(0, 15));
    mid = 6'($urandom);
    p   = $urandom_range(0, 13);
    if (p <= 7)       fn = 6'(p);
    else if (p == 8)  fn = 6'd25;
    else if (p == 9)  fn = 6'd26;
    else if (p == 10) fn = 6'd28;
    else              fn = 6'($urandom);
    if (op == 4'd15 && fn == 6'd29) fn = 6'd0;
    return {op, mid, fn};
  endfunction

  // memory answers a strobe after lat not-ready cycles
  task automatic step(input int idx, output smp_t r);
    int lat;
    @(negedge clk);
    lat = bus.i_or_d ? lat_mem : lat_if;
    if (bus.mem_read || bus.mem_write) begin
      if (pend < lat) begin
        bus.mem_ready = 1'b0;
        pend++;
      end else begin
        bus.mem_ready = 1'b1;
        pend = 0;
      end
    end else begin
      bus.mem_ready = 1'b0;
      pend = 0;
    end
    #1;
    r = grab();
    if (idx >= 0 && idx < 64) tr[idx] = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    pend = 0;
    #1;
    chk("reset_outs", 32'(grab()), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
    #1;
    chk("reset_cnt", 32'(bus.num_inst), 0);
    chk("reset_fetch",
        {bus.mem_read, bus.i_or_d,
         bus.halt, bus.timeout_err}, 4'b1000);
  endtask

  task automatic run_instr(input logic [15:0] ins,
                           input logic br,
                           input int wif,
                           input int wm);
    int   k, ecyc, emr, emw, eiod, erw;
    int   em2r, ewwd, epcw, epcs;
    int   cmr, cmw, ciod, crw, cm2r;
    int   cpcw, cirw, cwwd, cbad, lpcs;
    smp_t r;
    k = kind(ins);
    bus.instr = ins;
    bus.br_taken = br;
    lat_if = wif;
    lat_mem = wm;
    ecyc = wif + 2;
    if (k == K_BR || k == K_JPR || k == K_JRL) ecyc += 1;
    if (k == K_ALU) ecyc += 2;
    if (k == K_SWD) ecyc += wm + 2;
    if (k == K_LWD) ecyc += wm + 3;
    emr  = wif + 1 + ((k == K_LWD) ? wm + 1 : 0);
    emw  = (k == K_SWD) ? wm + 1 : 0;
    eiod = (k == K_LWD || k == K_SWD) ? wm + 1 : 0;
    erw  = (k inside {K_ALU, K_LWD, K_JAL, K_JRL}) ? 1 : 0;
    em2r = (k == K_LWD) ? 1 : 0;
    ewwd = (k == K_WWD) ? 1 : 0;
    epcw = 1;
    epcs = 0;
    if (k == K_BR && br) begin epcw = 2; epcs = 1; end
    if (k == K_JMP || k == K_JAL) begin epcw = 2; epcs = 2; end
    if (k == K_JPR || k == K_JRL) begin epcw = 2; epcs = 3; end
    cmr = 0; cmw = 0; ciod = 0; crw = 0; cm2r = 0;
    cpcw = 0; cirw = 0; cwwd = 0; cbad = 0; lpcs = 0;
    for (int i = 0; i < ecyc; i++) begin
      step(i, r);
      cmr  += int'(r.mr);
      cmw  += int'(r.mw);
      ciod += int'(r.iod);
      crw  += int'(r.rw);
      cm2r += int'(r.m2r);
      cirw += int'(r.irw);
      cwwd += int'(r.wwd);
      cbad += int'(r.halt | r.terr);
      if (r.pcw) begin
        cpcw++;
        lpcs = int'(r.pcs);
      end
    end
    @(posedge clk);
    #1;
    model_cnt = (model_cnt + 1) % (1 << CW);
    chk($sformatf("k%0d mem_read", k), cmr, emr);
    chk($sformatf("k%0d mem_write", k), cmw, emw);
    chk($sformatf("k%0d i_or_d", k), ciod, eiod);
    chk($sformatf("k%0d reg_write", k), crw, erw);
    chk($sformatf("k%0d mem_to_reg", k), cm2r, em2r);
    chk($sformatf("k%0d ir_write", k), cirw, 1);
    chk($sformatf("k%0d pc_write", k), cpcw, epcw);
    chk($sformatf("k%0d pc_source", k), lpcs, epcs);
    chk($sformatf("k%0d wwd", k), cwwd, ewwd);
    chk($sformatf("k%0d halt_err", k), cbad, 0);
    chk($sformatf("k%0d num_inst", k),
        32'(bus.num_inst), model_cnt);
    if (k == K_HLT)
      chk("halt_entry", {bus.halt, bus.mem_read}, 2'b10);
    else
      chk($sformatf("k%0d next_fetch", k),
          {bus.mem_read, bus.i_or_d, bus.halt}, 3'b100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.instr = 16'h0;
    bus.mem_ready = 1'b0;
    bus.br_taken = 1'b0;
    do_reset();

    // ADI, memory always ready
    run_instr(16'h4123, 1'b0, 0, 0);
    chk("adi_no_rw_early",
        {tr[0].rw, tr[1].rw, tr[2].rw}, 0);
    chk("adi_wb_rw", tr[3].rw, 1);

    // LWD with three not-ready MEM cycles
    run_instr(16'h7045, 1'b0, 0, 3);
    cnt = 0;
    for (int i = 0; i < 8; i++)
      cnt += int'(tr[i].mr & tr[i].iod);
    chk("lwd_mem_hold", cnt, 4);
    chk("lwd_ex_srcb", tr[2].asb, 2'b10);
    chk("lwd_wb_m2r", {tr[7].rw, tr[7].m2r}, 2'b11);

    // BEQ taken / not taken
    run_instr(16'h1000, 1'b1, 0, 0);
    chk("beq_t_ex", {tr[2].pcw, tr[2].pcs}, 3'b101);
    run_instr(16'h1000, 1'b0, 1, 0);
    chk("beq_nt_ex", tr[3].pcw, 0);

    for (int n = 0; n < 40; n++)
      run_instr(rnd_instr(), 1'($urandom),
                $urandom_range(0, 4),
                $urandom_range(0, 4));

    // reset while SWD waits in MEM
    bus.instr = 16'h8011;
    bus.br_taken = 1'b0;
    lat_if = 0;
    lat_mem = 20;
    for (int i = 0; i < 6; i++) step(i, s);
    chk("swd_mem_wait", {s.mw, s.iod}, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_mem_outs", 32'(grab()), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend = 0;
    model_cnt = 0;
    #1;
    chk("rst_mem_next",
        {bus.mem_read, bus.i_or_d, bus.mem_write}, 3'b100);
    chk("rst_mem_cnt", 32'(bus.num_inst), 0);

    // reset while IF waits
    lat_if = 20;
    for (int i = 0; i < 3; i++) step(i, s);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_if_outs", 32'(grab()), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend = 0;
    model_cnt = 0;

    // 17 undefined instructions wrap a 4-bit counter
    for (int n = 0; n < 17; n++)
      run_instr(n[0] ? 16'hB000 : 16'hF03F, 1'b0,
                $urandom_range(0, 2), 0);
    chk("cnt_wrap", 32'(bus.num_inst), 1);
    run_instr(16'hF01D, 1'b0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step(-1, s);
      chk("halt_hold",
          {s.halt, s.mr, s.mw, s.pcw, s.rw, s.irw},
          6'b100000);
      chk("halt_cnt", 32'(bus.num_inst), 2);
    end

    // fetch never answered
    do_reset();
    lat_if = 1000;
    for (int i = 0; i < 14; i++) step(i, s);
    @(posedge clk);
    #1;
    chk("tmo_before",
        {bus.timeout_err, bus.halt, bus.mem_read}, 3'b001);
    step(14, s);
    @(posedge clk);
    #1;
    chk("tmo_hit",
        {bus.timeout_err, bus.halt, bus.mem_read}, 3'b110);
    chk("tmo_cnt", 32'(bus.num_inst), 0);
    for (int i = 0; i < 5; i++) begin
      step(-1, s);
      chk("tmo_sticky", {s.terr, s.halt, s.mr}, 3'b110);
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
